// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
// States cover addressing, pointer load, write burst and read burst.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_PTR_NACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA pad synchronizers with history flops.
// Produces edge and START/STOP strobes from synchronized lines.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] synchronizer stages, [2] history
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // shift raw pads down the chain every cycle
  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  // idle bus is high, so reset to 1 to avoid phantom edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl       = scl_q[1];
  assign sda       = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2]
                   & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2]
                   &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an 8-bit register bank, pointer auto-increment,
// write bursts, read bursts, repeated START and STOP anywhere.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int NUM_REGS = 4,
  parameter int PTR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  busy
);

  localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_W - 1);
  localparam logic [3:0] FULL     = 4'(I2C_BYTE_W);
  localparam logic [7:0] NREG8    = 8'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

  logic scl, sda, scl_rise, scl_fall;
  logic start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic rw_q, rw_d;
  logic sda_oe_q, sda_oe_d;
  logic wr_stb_q, wr_stb_d;
  logic busy_q, busy_d;
  logic [NUM_REGS-1:0][I2C_BYTE_W-1:0] regs_q, regs_d;

  logic bit_rise, bit_fall;
  logic [7:0] byte_in;
  logic [7:0] cur_reg;
  logic [PTR_W-1:0] ptr_next;

  assign bit_rise = scl_rise & scl;
  assign bit_fall = scl_fall & ~scl;
  assign byte_in  = {shift_q[6:0], sda};
  assign cur_reg  = regs_q[ptr_q];
  assign ptr_next = (ptr_q == LAST_PTR) ? '0
                  : ptr_q + 1'b1;

  // next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    regs_d   = regs_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    busy_d   = busy_q;
    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (bit_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d = ST_ADDR_ACK;
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_PTR: if (bit_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (byte_in < NREG8) begin
              ptr_d   = byte_in[PTR_W-1:0];
              state_d = ST_PTR_ACK;
            end else begin
              state_d = ST_PTR_NACK;
            end
          end
        end
        ST_WDATA: if (bit_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) begin
            cnt_d         = '0;
            regs_d[ptr_q] = byte_in;
            wr_stb_d      = 1'b1;
            wr_idx_d      = ptr_q;
            ptr_d         = ptr_next;
            state_d       = ST_WDATA_ACK;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK,
        ST_WDATA_ACK, ST_PTR_NACK: if (bit_fall) begin
          if (cnt_q == 4'd0) begin
            cnt_d    = 4'd1;
            sda_oe_d = (state_q != ST_PTR_NACK);
          end else begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            if (state_q == ST_PTR_NACK) begin
              state_d = ST_WAIT_STOP;
            end else if (state_q != ST_ADDR_ACK) begin
              state_d = ST_WDATA;
            end else if (!rw_q) begin
              state_d = ST_PTR;
            end else begin
              state_d  = ST_RDATA;
              shift_d  = cur_reg;
              sda_oe_d = ~cur_reg[7];
            end
          end
        end
        ST_RDATA: begin
          if (bit_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (bit_fall) begin
            if (cnt_q == FULL) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (bit_rise) begin
            if (sda) begin
              state_d = ST_WAIT_STOP;
            end else begin
              ptr_d = ptr_next;
              cnt_d = 4'd1;
            end
          end else if (bit_fall && cnt_q == 4'd1) begin
            cnt_d    = '0;
            shift_d  = cur_reg;
            sda_oe_d = ~cur_reg[7];
            state_d  = ST_RDATA;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // all state clears at once on reset, releasing SDA immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      regs_q   <= '0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      regs_q   <= regs_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
      busy_q   <= busy_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign regs_o = regs_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged master on a
// wired-AND SDA, hand-computed expected register and read values.
module tb_i2c_slave_regfile;

  localparam int Q = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, wr_stb, busy;
  logic [31:0] regs_o;
  logic [1:0] wr_idx;
  logic sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h55),
    .NUM_REGS   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .regs_o (regs_o),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int busy_cyc = 0;
  logic [1:0] last_idx = '0;
  logic prev_stb = 1'b0;
  logic stb_wide = 1'b0;

  // strobe and busy monitors, sampled on the falling clock edge
  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt  = stb_cnt + 1;
      last_idx = wr_idx;
    end
    if (wr_stb && prev_stb) stb_wide = 1'b1;
    prev_stb = wr_stb;
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b; #(Q);
    scl_m = 1'b1; #(Q);
    r = sda_line; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ackb, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(ackb, r);
  endtask

  logic a;
  logic [7:0] d;
  logic r;
  int sb, bb;

  initial begin
    #20;
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_regs", regs_o, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    reset = 1'b0;
    #(Q);

    sb = stb_cnt;
    i2c_start();
    wr_byte(8'hAA, a); chk("w1_addr_ack", 32'(a), 32'd0);
    wr_byte(8'h01, a); chk("w1_ptr_ack", 32'(a), 32'd0);
    wr_byte(8'hA5, a); chk("w1_data_ack", 32'(a), 32'd0);
    chk("w1_busy", 32'(busy), 32'd1);
    i2c_stop();
    chk("w1_stb_cnt", 32'(stb_cnt - sb), 32'd1);
    chk("w1_wr_idx", 32'(last_idx), 32'd1);
    chk("w1_reg1", 32'(regs_o[15:8]), 32'hA5);
    chk("w1_regs", regs_o, 32'h0000A500);
    chk("w1_busy_end", 32'(busy), 32'd0);

    sb = stb_cnt;
    i2c_start();
    wr_byte(8'hAA, a);
    wr_byte(8'h03, a); chk("bw_ptr_ack", 32'(a), 32'd0);
    wr_byte(8'h11, a);
    wr_byte(8'h22, a); chk("bw_d2_ack", 32'(a), 32'd0);
    i2c_stop();
    chk("bw_stb_cnt", 32'(stb_cnt - sb), 32'd2);
    chk("bw_wr_idx", 32'(last_idx), 32'd0);
    chk("bw_regs", regs_o, 32'h1100A522);

    sb = stb_cnt;
    bb = busy_cyc;
    i2c_start();
    wr_byte(8'hA8, a); chk("na_addr_nack", 32'(a), 32'd1);
    wr_byte(8'h03, a); chk("na_byte2_nack", 32'(a), 32'd1);
    i2c_stop();
    chk("na_stb_cnt", 32'(stb_cnt - sb), 32'd0);
    chk("na_busy_cyc", 32'(busy_cyc - bb), 32'd0);
    chk("na_regs", regs_o, 32'h1100A522);

    i2c_start();
    wr_byte(8'hAA, a);
    wr_byte(8'h02, a);
    wr_byte(8'h3C, a);
    i2c_stop();
    chk("w2_regs", regs_o, 32'h113CA522);

    i2c_start();
    wr_byte(8'hAA, a);
    wr_byte(8'h02, a);
    i2c_rstart();
    wr_byte(8'hAB, a); chk("rd_addr_ack", 32'(a), 32'd0);
    rd_byte(1'b0, d);  chk("rd_byte0", 32'(d), 32'h3C);
    rd_byte(1'b1, d);  chk("rd_byte1", 32'(d), 32'h11);
    chk("rd_release", 32'(sda_oe), 32'd0);
    clk_bit(1'b1, r);  chk("rd_after_nack", 32'(r), 32'd1);
    i2c_stop();

    i2c_start();
    wr_byte(8'hAB, a); chk("rp_addr_ack", 32'(a), 32'd0);
    rd_byte(1'b1, d);  chk("rp_persist", 32'(d), 32'h11);
    i2c_stop();

    sb = stb_cnt;
    i2c_start();
    wr_byte(8'hAA, a); chk("bp_addr_ack", 32'(a), 32'd0);
    wr_byte(8'h07, a); chk("bp_ptr_nack", 32'(a), 32'd1);
    wr_byte(8'h99, a); chk("bp_data_nack", 32'(a), 32'd1);
    i2c_stop();
    chk("bp_stb_cnt", 32'(stb_cnt - sb), 32'd0);
    chk("bp_regs", regs_o, 32'h113CA522);
    chk("bp_busy", 32'(busy), 32'd0);

    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'hAA;
      clk_bit(d[i], r);
    end
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q/2);
    chk("rs_ack_drive", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_sda_oe", 32'(sda_oe), 32'd0);
    chk("rs_regs", regs_o, 32'h0);
    chk("rs_busy", 32'(busy), 32'd0);
    #(Q/2 - 1);
    scl_m = 1'b1; sda_m = 1'b1;
    #(Q);
    reset = 1'b0;
    #(Q);

    chk("stb_width", 32'(stb_wide), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
